// File: rtl/tx_frame_arbiter_if.sv
// Transmit-side bundle between the two frame sources, the arbiter and the
// downstream CRC/PHY path.
interface tx_frame_arbiter_if;
  logic       i_Req0;
  logic       i_Valid0;
  logic [7:0] i_Data0;
  logic       i_End0;
  logic       o_Gnt0;
  logic       i_Req1;
  logic       i_Valid1;
  logic [7:0] i_Data1;
  logic       i_End1;
  logic       o_Gnt1;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Sync;
  logic       o_End;
  logic       o_Busy;
  logic       o_Abort;

  modport master (
    output i_Req0, i_Valid0, i_Data0, i_End0,
    output i_Req1, i_Valid1, i_Data1, i_End1,
    input  o_Gnt0, o_Gnt1, o_Data, o_Valid, o_Sync, o_End, o_Busy, o_Abort
  );

  modport slave (
    input  i_Req0, i_Valid0, i_Data0, i_End0,
    input  i_Req1, i_Valid1, i_Data1, i_End1,
    output o_Gnt0, o_Gnt1, o_Data, o_Valid, o_Sync, o_End, o_Busy, o_Abort
  );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Two-source round-robin arbiter for the shared Ethernet transmit path:
// frame delimiting, inter-frame gap, length limit and grant timeout.
module tx_frame_arbiter #(
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned MAX_BYTES   = 1518,
  parameter int unsigned GNT_TIMEOUT = 64
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  tx_frame_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);
  localparam logic [7:0]  IFG_LD  = 8'(IFG_CYCLES);
  localparam logic [7:0]  TMO_LD  = 8'(GNT_TIMEOUT);

  state_t      state_r, next_state_s, end_state_s;
  logic        sel_r, sel_s;
  logic        last_gnt_r, last_gnt_s;
  logic [10:0] byte_cnt_r, byte_cnt_s, cnt_inc_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_s;
  logic [7:0]  ifg_cnt_r, ifg_cnt_s;
  logic        any_req_s, pick_s;
  logic        src_valid_s, src_end_s, frame_last_s;
  logic [7:0]  src_data_s;
  logic        gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s, sync_r, sync_s, end_r, end_s;
  logic        busy_r, busy_s, abort_r, abort_s;

  // Source selection, round-robin pick and frame-length bookkeeping
  always_comb begin
    any_req_s = bus.i_Req0 | bus.i_Req1;
    if (bus.i_Req0 && bus.i_Req1) begin
      pick_s = ~last_gnt_r;
    end else if (bus.i_Req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (sel_r) begin
      src_valid_s = bus.i_Valid1;
      src_end_s   = bus.i_End1;
      src_data_s  = bus.i_Data1;
    end else begin
      src_valid_s = bus.i_Valid0;
      src_end_s   = bus.i_End0;
      src_data_s  = bus.i_Data0;
    end
    cnt_inc_s    = (byte_cnt_r >= MAX_CNT) ? MAX_CNT : (byte_cnt_r + 11'd1);
    frame_last_s = src_end_s | (cnt_inc_s == MAX_CNT);
    end_state_s  = (IFG_LD == 8'd0) ? ST_IDLE : ST_GAP;
  end

  // FSM state register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_GRANT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (src_valid_s) begin
          next_state_s = frame_last_s ? end_state_s : ST_XFER;
        end else if (tmo_cnt_r <= 8'd1) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GRANT;
        end
      end
      ST_XFER: begin
        if (src_valid_s && frame_last_s) begin
          next_state_s = end_state_s;
        end else begin
          next_state_s = ST_XFER;
        end
      end
      ST_GAP: begin
        if (ifg_cnt_r == 8'd0) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of outputs and counters
  always_comb begin
    sel_s      = sel_r;
    last_gnt_s = last_gnt_r;
    byte_cnt_s = byte_cnt_r;
    tmo_cnt_s  = tmo_cnt_r;
    ifg_cnt_s  = ifg_cnt_r;
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    data_s     = 8'h00;
    valid_s    = 1'b0;
    sync_s     = 1'b0;
    end_s      = 1'b0;
    abort_s    = 1'b0;
    busy_s     = (next_state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (next_state_s == ST_GRANT) begin
          sel_s      = pick_s;
          last_gnt_s = pick_s;
          gnt0_s     = ~pick_s;
          gnt1_s     = pick_s;
          byte_cnt_s = 11'd0;
          tmo_cnt_s  = TMO_LD;
        end else begin
          sel_s = sel_r;
        end
      end
      ST_GRANT, ST_XFER: begin
        gnt0_s = ~sel_r;
        gnt1_s = sel_r;
        if (src_valid_s) begin
          valid_s    = 1'b1;
          data_s     = src_data_s;
          sync_s     = (state_r == ST_GRANT);
          byte_cnt_s = cnt_inc_s;
          if (frame_last_s) begin
            // A length-limit end still closes the frame, but flags the abort
            end_s     = 1'b1;
            abort_s   = ~src_end_s;
            gnt0_s    = 1'b0;
            gnt1_s    = 1'b0;
            ifg_cnt_s = IFG_LD;
          end else begin
            ifg_cnt_s = ifg_cnt_r;
          end
        end else if (state_r == ST_GRANT) begin
          if (tmo_cnt_r <= 8'd1) begin
            abort_s   = 1'b1;
            gnt0_s    = 1'b0;
            gnt1_s    = 1'b0;
            tmo_cnt_s = 8'd0;
          end else begin
            tmo_cnt_s = tmo_cnt_r - 8'd1;
          end
        end else begin
          tmo_cnt_s = tmo_cnt_r;
        end
      end
      ST_GAP: begin
        if (ifg_cnt_r != 8'd0) begin
          ifg_cnt_s = ifg_cnt_r - 8'd1;
        end else begin
          ifg_cnt_s = ifg_cnt_r;
        end
      end
      default: begin
        sel_s = sel_r;
      end
    endcase
  end

  // Output and counter registers; last-granted resets to port 1 so port 0 wins the first tie
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sel_r      <= 1'b0;
      last_gnt_r <= 1'b1;
      byte_cnt_r <= 11'd0;
      tmo_cnt_r  <= 8'd0;
      ifg_cnt_r  <= 8'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      data_r     <= 8'h00;
      valid_r    <= 1'b0;
      sync_r     <= 1'b0;
      end_r      <= 1'b0;
      busy_r     <= 1'b0;
      abort_r    <= 1'b0;
    end else begin
      sel_r      <= sel_s;
      last_gnt_r <= last_gnt_s;
      byte_cnt_r <= byte_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      ifg_cnt_r  <= ifg_cnt_s;
      gnt0_r     <= gnt0_s;
      gnt1_r     <= gnt1_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      sync_r     <= sync_s;
      end_r      <= end_s;
      busy_r     <= busy_s;
      abort_r    <= abort_s;
    end
  end

  assign bus.o_Gnt0  = gnt0_r;
  assign bus.o_Gnt1  = gnt1_r;
  assign bus.o_Data  = data_r;
  assign bus.o_Valid = valid_r;
  assign bus.o_Sync  = sync_r;
  assign bus.o_End   = end_r;
  assign bus.o_Busy  = busy_r;
  assign bus.o_Abort = abort_r;

endmodule
